// File: rtl/axi_wr_req_arbiter.sv
// Round-robin arbiter sharing one AXI write controller between NUM_REQ requesters:
// grants, latches controls, streams the owner's beats and routes the write response back.
module axi_wr_req_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int addr_width   = 32,
    parameter int data_width   = 64,
    parameter int strobe_width = data_width / 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                             AClk,
    input  logic                             ARst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*addr_width-1:0]    req_addr,
    input  logic [NUM_REQ*4-1:0]             req_len,
    input  logic [NUM_REQ*3-1:0]             req_size,
    input  logic [NUM_REQ*2-1:0]             req_burst,
    input  logic [NUM_REQ*2-1:0]             req_lock,
    input  logic [NUM_REQ*2-1:0]             req_cache,
    input  logic [NUM_REQ*3-1:0]             req_prot,
    input  logic [NUM_REQ*data_width-1:0]    req_wdata,
    input  logic [NUM_REQ*strobe_width-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]               req_wready,
    output logic [addr_width-1:0]            awaddr_d,
    output logic [3:0]                       awlen_d,
    output logic [2:0]                       awsize_d,
    output logic [1:0]                       awburst_d,
    output logic [1:0]                       awlock_d,
    output logic [1:0]                       awcache_d,
    output logic [2:0]                       awprot_d,
    output logic [3:0]                       TXN_ID_W_d,
    output logic [data_width-1:0]            wdata_d,
    output logic [strobe_width-1:0]          wstrb_d,
    output logic                             wr_trn_en,
    input  logic                             wr_beat_ack,
    input  logic [1:0]                       bresp_d,
    input  logic [3:0]                       bid_d,
    input  logic                             wr_rsp_en_d,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [1:0]                       rsp_resp,
    output logic [3:0]                       rsp_id,
    output logic                             busy,
    output logic                             id_err,
    output logic                             timeout_err
);

    localparam int          IdxW   = $clog2(NUM_REQ);
    localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        DATA     = 2'd2,
        WAIT_RSP = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         grantIdx_q;
    logic [IdxW-1:0]         lastGrant_q;
    logic [IdxW-1:0]         winnerIdx;
    logic [NUM_REQ-1:0]      winnerOh;
    logic [NUM_REQ-1:0]      grantOh;
    logic                    anyReq;
    logic [4:0]              beatCnt_q;
    logic [15:0]             toCnt_q;

    logic [addr_width-1:0]   awaddr_q;
    logic [3:0]              awlen_q;
    logic [2:0]              awsize_q;
    logic [1:0]              awburst_q;
    logic [1:0]              awlock_q;
    logic [1:0]              awcache_q;
    logic [2:0]              awprot_q;
    logic [3:0]              txnId_q;

    logic [NUM_REQ-1:0]      reqReady_q;
    logic [NUM_REQ-1:0]      rspValid_q;
    logic                    wrTrnEn_q;
    logic                    timeoutErr_q;
    logic                    idErr_q;
    logic [1:0]              rspResp_q;
    logic [3:0]              rspId_q;

    logic                    beatAck;
    logic                    lastBeat;
    logic                    rspFire;
    logic                    toFire;

    // Search starts one past the previous owner so every pending requester is served in turn.
    always_comb begin
        int              cand;
        logic [IdxW-1:0] candIdx;
        cand      = 0;
        candIdx   = '0;
        anyReq    = 1'b0;
        winnerIdx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(lastGrant_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = IdxW'(cand);
            if (!anyReq && req_valid[candIdx]) begin
                anyReq    = 1'b1;
                winnerIdx = candIdx;
            end
        end
    end

    always_comb begin
        winnerOh            = '0;
        winnerOh[winnerIdx] = 1'b1;
        grantOh             = '0;
        grantOh[grantIdx_q] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        beatAck  = 1'b0;
        lastBeat = 1'b0;
        rspFire  = 1'b0;
        toFire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = DATA;
            end
            DATA: begin
                if (wr_beat_ack) begin
                    beatAck = 1'b1;
                    if (beatCnt_q == 5'd1) begin
                        lastBeat = 1'b1;
                        state_d  = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                // A real response in the final allowed cycle beats the timeout.
                if (wr_rsp_en_d) begin
                    rspFire = 1'b1;
                    state_d = IDLE;
                end else if (toCnt_q == ToLast) begin
                    toFire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_wready = '0;
        wdata_d    = '0;
        wstrb_d    = '0;
        busy       = (state_q != IDLE);
        if (state_q == DATA) begin
            req_wready[grantIdx_q] = wr_beat_ack;
            wdata_d = req_wdata[grantIdx_q*data_width +: data_width];
            wstrb_d = req_wstrb[grantIdx_q*strobe_width +: strobe_width];
        end
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            grantIdx_q   <= '0;
            lastGrant_q  <= IdxW'(NUM_REQ - 1);
            beatCnt_q    <= '0;
            toCnt_q      <= '0;
            awaddr_q     <= '0;
            awlen_q      <= '0;
            awsize_q     <= '0;
            awburst_q    <= '0;
            awlock_q     <= '0;
            awcache_q    <= '0;
            awprot_q     <= '0;
            txnId_q      <= '0;
            reqReady_q   <= '0;
            rspValid_q   <= '0;
            wrTrnEn_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
            idErr_q      <= 1'b0;
            rspResp_q    <= '0;
            rspId_q      <= '0;
        end else begin
            reqReady_q   <= '0;
            rspValid_q   <= '0;
            wrTrnEn_q    <= 1'b0;
            timeoutErr_q <= 1'b0;

            if (state_q == IDLE && anyReq) begin
                grantIdx_q <= winnerIdx;
                txnId_q    <= 4'(winnerIdx);
                awaddr_q   <= req_addr[winnerIdx*addr_width +: addr_width];
                awlen_q    <= req_len[winnerIdx*4 +: 4];
                awsize_q   <= req_size[winnerIdx*3 +: 3];
                awburst_q  <= req_burst[winnerIdx*2 +: 2];
                awlock_q   <= req_lock[winnerIdx*2 +: 2];
                awcache_q  <= req_cache[winnerIdx*2 +: 2];
                awprot_q   <= req_prot[winnerIdx*3 +: 3];
                reqReady_q <= winnerOh;
                wrTrnEn_q  <= 1'b1;
            end

            if (state_q == GRANT) begin
                beatCnt_q   <= {1'b0, awlen_q} + 5'd1;
                lastGrant_q <= grantIdx_q;
            end else if (beatAck) begin
                beatCnt_q <= beatCnt_q - 5'd1;
            end

            if (lastBeat) begin
                toCnt_q <= '0;
            end else if (state_q == WAIT_RSP) begin
                toCnt_q <= toCnt_q + 16'd1;
            end

            // The response always returns to the owner, even when its ID disagrees.
            if (rspFire) begin
                rspValid_q <= grantOh;
                rspResp_q  <= bresp_d;
                rspId_q    <= bid_d;
                if (bid_d != txnId_q) begin
                    idErr_q <= 1'b1;
                end
            end else if (toFire) begin
                rspValid_q   <= grantOh;
                rspResp_q    <= 2'b10;
                rspId_q      <= txnId_q;
                timeoutErr_q <= 1'b1;
            end
        end
    end

    assign req_ready   = reqReady_q;
    assign wr_trn_en   = wrTrnEn_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_resp    = rspResp_q;
    assign rsp_id      = rspId_q;
    assign timeout_err = timeoutErr_q;
    assign id_err      = idErr_q;
    assign awaddr_d    = awaddr_q;
    assign awlen_d     = awlen_q;
    assign awsize_d    = awsize_q;
    assign awburst_d   = awburst_q;
    assign awlock_d    = awlock_q;
    assign awcache_d   = awcache_q;
    assign awprot_d    = awprot_q;
    assign TXN_ID_W_d  = txnId_q;

endmodule
